// File: rtl/fusion_pkg.sv
// rtl/fusion_pkg.sv - shared constants, state enum and brick helpers for the bit-fusion decomposer
package fusion_pkg;

  localparam int BRICK_W = 2;
  localparam int P_W     = 10;
  localparam int SHIFT_W = 4;

  localparam logic [1:0] PREC_2 = 2'b00;
  localparam logic [1:0] PREC_4 = 2'b01;
  localparam logic [1:0] PREC_8 = 2'b10;

  typedef enum logic {IDLE, EMIT} state_e;

  // Encoding 2'b11 falls through to the 8-bit case.
  function automatic logic [2:0] num_bricks(input logic [1:0] prec);
    case (prec)
      PREC_2:  return 3'd1;
      PREC_4:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [BRICK_W-1:0] brick(input logic [7:0] op, input int idx);
    return BRICK_W'(op >> (BRICK_W * idx));
  endfunction

endpackage

// File: rtl/fusion_brick_mul.sv
// rtl/fusion_brick_mul.sv - 2x2 brick multiplier with per-operand signedness, sign-extended product
module fusion_brick_mul
  import fusion_pkg::*;
(
  input  logic [BRICK_W-1:0] a_i,
  input  logic [BRICK_W-1:0] b_i,
  input  logic               a_signed_i,
  input  logic               b_signed_i,
  output logic [P_W-1:0]     p_o
);

  logic signed [BRICK_W:0]     a_x;
  logic signed [BRICK_W:0]     b_x;
  logic signed [2*BRICK_W+1:0] prod;

  assign a_x  = {a_signed_i & a_i[BRICK_W-1], a_i};
  assign b_x  = {b_signed_i & b_i[BRICK_W-1], b_i};
  assign prod = a_x * b_x;
  assign p_o  = {{(P_W-2*BRICK_W-2){prod[2*BRICK_W+1]}}, prod};

endmodule

// File: rtl/fusion_decomposer.sv
// rtl/fusion_decomposer.sv - splits an operand pair into brick cross-products, one beat per shift group (FUSION_DECOMP_ZSKIP_EN skips all-zero beats)
module fusion_decomposer
  import fusion_pkg::state_e, fusion_pkg::IDLE, fusion_pkg::EMIT, fusion_pkg::num_bricks, fusion_pkg::brick;
#(
  parameter int OP_W    = 8,
  parameter int BRICK_W = 2,
  parameter int P_W     = 10,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_a,
  input  logic [OP_W-1:0]    in_b,
  input  logic [1:0]         in_prec,
  input  logic               in_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_W-1:0]     out_p0,
  output logic [P_W-1:0]     out_p1,
  output logic [P_W-1:0]     out_p2,
  output logic [P_W-1:0]     out_p3,
  output logic [SHIFT_W-1:0] out_shift,
  output logic               out_sign,
  output logic               out_last
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]        prec_q, prec_d;
  logic              sign_q, sign_d;
  logic [2:0]        k_q, k_d;
  logic [2:0]        n, kmax;
  logic              emit, last;
  int                imin, imax;
  logic [BRICK_W-1:0] abr [4];
  logic [BRICK_W-1:0] bbr [4];
  logic              asg [4];
  logic              bsg [4];
  logic [P_W-1:0]    prod [4];

  assign n    = num_bricks(prec_q);
  assign kmax = 3'({n, 1'b0} - 4'd2);
  assign emit = (state_q == EMIT);
  assign last = emit && (k_q == kmax);

`ifdef FUSION_DECOMP_ZSKIP_EN
  // A cross-product is zero exactly when either brick is zero.
  function automatic logic beat_nz(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                   input int nb, input int k);
    beat_nz = 1'b0;
    for (int i = 0; i < 4; i++)
      if (i < nb && k - i >= 0 && k - i < nb && brick(a, i) != '0 && brick(b, k - i) != '0)
        beat_nz = 1'b1;
  endfunction

  function automatic logic [2:0] first_k(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                         input logic [2:0] nb, input logic [2:0] from);
    int km;
    km      = 2 * int'(nb) - 2;
    first_k = 3'(km);
    for (int k = 6; k >= 0; k--)
      if (k >= int'(from) && k < km && beat_nz(a, b, int'(nb), k))
        first_k = 3'(k);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      prec_q  <= '0;
      sign_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prec_q  <= prec_d;
      sign_q  <= sign_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    prec_d   = prec_q;
    sign_d   = sign_q;
    k_d      = k_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          prec_d  = in_prec;
          sign_d  = in_sign;
          state_d = EMIT;
`ifdef FUSION_DECOMP_ZSKIP_EN
          k_d     = first_k(in_a, in_b, num_bricks(in_prec), 3'd0);
`else
          k_d     = 3'd0;
`endif
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last) begin
            state_d = IDLE;
            k_d     = 3'd0;
          end else begin
`ifdef FUSION_DECOMP_ZSKIP_EN
            k_d = first_k(a_q, b_q, n, k_q + 3'd1);
`else
            k_d = k_q + 3'd1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot s carries pair (imin+s, k-imin-s); idle or unused slots see zero bricks.
  always_comb begin
    imin = (int'(k_q) >= int'(n)) ? int'(k_q) - int'(n) + 1 : 0;
    imax = (int'(k_q) < int'(n)) ? int'(k_q) : int'(n) - 1;
    for (int s = 0; s < 4; s++) begin
      abr[s] = '0;
      bbr[s] = '0;
      asg[s] = 1'b0;
      bsg[s] = 1'b0;
      if (emit && imin + s <= imax) begin
        abr[s] = brick(a_q, imin + s);
        bbr[s] = brick(b_q, int'(k_q) - imin - s);
        asg[s] = sign_q && (imin + s == int'(n) - 1);
        bsg[s] = sign_q && (int'(k_q) - imin - s == int'(n) - 1);
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_slot
    fusion_brick_mul u_mul (
      .a_i        (abr[g]),
      .b_i        (bbr[g]),
      .a_signed_i (asg[g]),
      .b_signed_i (bsg[g]),
      .p_o        (prod[g])
    );
  end

  assign out_valid = emit;
  assign out_last  = last;
  assign out_sign  = emit & sign_q;
  assign out_shift = emit ? SHIFT_W'({k_q, 1'b0}) : '0;
  assign out_p0    = prod[0];
  assign out_p1    = prod[1];
  assign out_p2    = prod[2];
  assign out_p3    = prod[3];

endmodule

// File: tb/tb_fusion_decomposer.sv
// tb/tb_fusion_decomposer.sv - scoreboard bench for fusion_decomposer: directed and random operand pairs
module tb_fusion_decomposer;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, in_sign, out_valid, out_ready, out_sign, out_last;
  logic [7:0] in_a, in_b;
  logic [1:0] in_prec;
  logic [9:0] out_p0, out_p1, out_p2, out_p3;
  logic [3:0] out_shift;

  typedef struct packed {
    logic [9:0] p0, p1, p2, p3;
    logic [3:0] shift;
    logic       sign;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  fusion_decomposer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_prec(in_prec), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p0(out_p0), .out_p1(out_p1), .out_p2(out_p2), .out_p3(out_p3),
    .out_shift(out_shift), .out_sign(out_sign), .out_last(out_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbricks(input logic [1:0] prec);
    return (prec == 2'd0) ? 1 : (prec == 2'd1) ? 2 : 4;
  endfunction

  function automatic int bval(input logic [7:0] op, input int idx, input int nb, input logic sg);
    int v;
    v = int'((op >> (2 * idx)) & 8'h03);
    if (sg && idx == nb - 1 && v >= 2) v -= 4;
    return v;
  endfunction

  function automatic int ref_product(input logic [7:0] a, input logic [7:0] b,
                                     input logic [1:0] prec, input logic sg);
    int w, av, bv;
    w  = 2 * nbricks(prec);
    av = int'(a) % (1 << w);
    bv = int'(b) % (1 << w);
    if (sg && av >= (1 << (w - 1))) av -= (1 << w);
    if (sg && bv >= (1 << (w - 1))) bv -= (1 << w);
    return av * bv;
  endfunction

  task automatic push_expected(input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] prec, input logic sg);
    int nb, kmax, slot, pr;
    logic nz;
    beat_t e;
    nb   = nbricks(prec);
    kmax = 2 * nb - 2;
    for (int k = 0; k <= kmax; k++) begin
      e    = '0;
      slot = 0;
      nz   = 1'b0;
      for (int i = 0; i < nb; i++) begin
        if (k - i >= 0 && k - i < nb) begin
          pr = bval(a, i, nb, sg) * bval(b, k - i, nb, sg);
          if (pr != 0) nz = 1'b1;
          case (slot)
            0: e.p0 = 10'(pr);
            1: e.p1 = 10'(pr);
            2: e.p2 = 10'(pr);
            default: e.p3 = 10'(pr);
          endcase
          slot++;
        end
      end
      e.shift = 4'(2 * k);
      e.sign  = sg;
      e.last  = (k == kmax);
`ifdef FUSION_DECOMP_ZSKIP_EN
      if (!nz && k != kmax) continue;
`endif
      sb.push_back(e);
    end
  endtask

  task automatic check_beat(input string tag, input beat_t e);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_p0"}, out_p0, e.p0);
    chk({tag, "_p1"}, out_p1, e.p1);
    chk({tag, "_p2"}, out_p2, e.p2);
    chk({tag, "_p3"}, out_p3, e.p3);
    chk({tag, "_shift"}, out_shift, e.shift);
    chk({tag, "_sign"}, out_sign, e.sign);
    chk({tag, "_last"}, out_last, e.last);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_sign"}, out_sign, 0);
    chk({tag, "_out_p"}, {out_p0, out_p1, out_p2, out_p3}, 40'h0);
    chk({tag, "_out_shift"}, out_shift, 0);
  endtask

  // stall_shift / abort_shift select the beat (by shift) to stall on or reset during; -1 disables.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] prec,
                        input logic sg, input int stall_shift, input int abort_shift);
    int    sum, t;
    bit    done;
    beat_t e;
    sum  = 0;
    done = 0;
    push_expected(a, b, prec, sg);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_a = a; in_b = b; in_prec = prec; in_sign = sg; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_prec = 2'($urandom); in_sign = 1'($urandom);
    chk("first_beat_latency", out_valid, 1);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", out_valid, 0);
          done = 1;
        end else begin
          e = sb.pop_front();
          check_beat("beat", e);
          t = int'($signed(out_p0)) + int'($signed(out_p1)) + int'($signed(out_p2)) + int'($signed(out_p3));
          sum += t <<< out_shift;
          if (abort_shift == int'(out_shift)) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check_idle_outputs("abort");
            sb.delete();
            return;
          end
          if (stall_shift == int'(out_shift)) begin
            out_ready = 1'b0;
            repeat (3) begin
              @(negedge clk);
              check_beat("stall", e);
              chk("stall_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
          end
          if (e.last) done = 1;
        end
      end
      if (!done) @(negedge clk);
    end
    chk("op_done", done, 1);
    chk("sb_empty", sb.size(), 0);
    chk("reconstruct", sum, ref_product(a, b, prec, sg));
    @(negedge clk);
    check_idle_outputs("after_last");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_prec = '0; in_sign = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    run_op(8'hF2, 8'hA7, 2'b00, 1'b1, -1, -1);
    run_op(8'h5F, 8'hCF, 2'b01, 1'b0, -1, -1);
    run_op(8'h80, 8'h7F, 2'b10, 1'b1, -1, -1);
    run_op(8'hC5, 8'h3A, 2'b10, 1'b1, 4, -1);
    run_op(8'h96, 8'h69, 2'b10, 1'b1, -1, 8);
    run_op(8'h5A, 8'hA5, 2'b10, 1'b0, -1, -1);
    run_op(8'h00, 8'h55, 2'b10, 1'b0, -1, -1);
    run_op(8'hFF, 8'h81, 2'b11, 1'b1, -1, -1);
    for (int r = 0; r < 8; r++)
      run_op(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
